// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: FSM states, pattern modes and the
// default LED count.
package led_seq_pkg;

    localparam int N_LEDS_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_DOT    = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_BOUNCE = 2'd2
    } seq_mode_e;

endpackage

// File: rtl/led_seq_presc.sv
// Step-rate prescaler: counts 0..term and ticks on the terminal count while
// enabled. load_i latches a new terminal value and restarts the count.
module led_seq_presc
    import led_seq_pkg::*;
#(
    parameter int                 PRESC_W    = 28,
    parameter logic [PRESC_W-1:0] RESET_TERM = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] term_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] count_q, count_d;
    logic [PRESC_W-1:0] term_q, term_d;
    logic               atTerm;

    assign atTerm = (count_q == term_q);
    assign tick_o = en_i && atTerm;

    // With en_i low the count holds, so a terminal value survives a pause.
    always_comb begin
        count_d = count_q;
        term_d  = term_q;
        if (load_i) begin
            count_d = '0;
            term_d  = term_i;
        end else if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = atTerm ? '0 : count_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            term_q  <= RESET_TERM;
        end else begin
            count_q <= count_d;
            term_q  <= term_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED chaser sequencer: run/pause/stop FSM, position/direction stepping and
// dot/fill/bounce decode. Define LED_SEQ_LOOP_LIMIT_EN for the loops/done limit.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int N_LEDS   = N_LEDS_DEFAULT,
    parameter int BASE_DIV = 5000000,
    parameter int PRESC_W  = 28
) (
    input  logic              ck_i,
    input  logic              rs_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              pause_i,
    input  logic [1:0]        mode_i,
    input  logic [3:0]        speed_i,
`ifdef LED_SEQ_LOOP_LIMIT_EN
    input  logic [3:0]        loops_i,
    output logic              done_o,
`endif
    output logic [N_LEDS-1:0] leds_o,
    output logic [3:0]        pos_o,
    output logic              busy_o,
    output logic              wrap_o
);

    localparam logic [3:0]         LAST_POS = 4'(N_LEDS - 1);
    localparam logic [PRESC_W-1:0] DIV_W    = PRESC_W'(BASE_DIV);

    seq_state_e          state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [3:0]          pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [N_LEDS-1:0]   leds_q, leds_d;
    logic                wrap_q, wrap_d;

    logic [3:0]          stepPos;
    logic                stepDir;
    logic                stepWrap;
    logic                limitHit;

    logic                prescLoad;
    logic                prescClr;
    logic                prescEn;
    logic                prescTick;
    logic [PRESC_W-1:0]  termIn;

`ifdef LED_SEQ_LOOP_LIMIT_EN
    logic [3:0]          loops_q, loops_d;
    logic [3:0]          wrapCnt_q, wrapCnt_d;
    logic                done_q, done_d;

    assign limitHit = (loops_q != 4'd0) && (wrapCnt_q == loops_q) && (state_q != ST_IDLE);
    assign done_o   = done_q;
`else
    assign limitHit = 1'b0;
`endif

    assign termIn = DIV_W * PRESC_W'({1'b0, speed_i} + 5'd1) - PRESC_W'(1);

    led_seq_presc #(
        .PRESC_W    (PRESC_W),
        .RESET_TERM (DIV_W - PRESC_W'(1))
    ) u_presc (
        .clk_i  (ck_i),
        .rst_i  (rs_i),
        .load_i (prescLoad),
        .clr_i  (prescClr),
        .en_i   (prescEn),
        .term_i (termIn),
        .tick_o (prescTick)
    );

    function automatic logic [N_LEDS-1:0] decodeLeds(input logic [1:0] m, input logic [3:0] p);
        logic [N_LEDS-1:0] one;
        one = N_LEDS'(1) << p;
        if (m == MODE_FILL) begin
            return (one << 1) - N_LEDS'(1);
        end
        return one;
    endfunction

    // Bounce shows each endpoint once: dir flips on the step that lands on it.
    always_comb begin
        stepPos  = pos_q + 4'd1;
        stepDir  = 1'b0;
        stepWrap = 1'b0;
        if (mode_q == MODE_BOUNCE) begin
            if (dir_q) begin
                stepPos  = pos_q - 4'd1;
                stepDir  = (stepPos != 4'd0);
                stepWrap = (stepPos == 4'd0);
            end else begin
                stepDir  = (stepPos == LAST_POS);
            end
        end else if (pos_q == LAST_POS) begin
            stepPos  = 4'd0;
            stepWrap = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        leds_d    = leds_q;
        wrap_d    = 1'b0;
        prescLoad = 1'b0;
        prescClr  = 1'b0;
        prescEn   = 1'b0;
`ifdef LED_SEQ_LOOP_LIMIT_EN
        loops_d   = loops_q;
        wrapCnt_d = wrapCnt_q;
        done_d    = 1'b0;
`endif
        if (stop_i) begin
            state_d  = ST_IDLE;
            pos_d    = 4'd0;
            dir_d    = 1'b0;
            leds_d   = '0;
            prescClr = 1'b1;
        end else if (start_i) begin
            state_d   = ST_RUN;
            mode_d    = mode_i;
            pos_d     = 4'd0;
            dir_d     = 1'b0;
            leds_d    = decodeLeds(mode_i, 4'd0);
            prescLoad = 1'b1;
`ifdef LED_SEQ_LOOP_LIMIT_EN
            loops_d   = loops_i;
            wrapCnt_d = 4'd0;
`endif
        end else if (limitHit) begin
            state_d  = ST_IDLE;
            pos_d    = 4'd0;
            dir_d    = 1'b0;
            leds_d   = '0;
            prescClr = 1'b1;
`ifdef LED_SEQ_LOOP_LIMIT_EN
            done_d   = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A pause on the terminal cycle freezes the count, so the step
                    // fires on the first edge after resuming.
                    if (pause_i) begin
                        state_d = ST_PAUSED;
                    end else begin
                        prescEn = 1'b1;
                        if (prescTick) begin
                            pos_d  = stepPos;
                            dir_d  = stepDir;
                            leds_d = decodeLeds(mode_q, stepPos);
                            wrap_d = stepWrap;
`ifdef LED_SEQ_LOOP_LIMIT_EN
                            wrapCnt_d = wrapCnt_q + {3'd0, stepWrap};
`endif
                        end
                    end
                end
                ST_PAUSED: begin
                    if (pause_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    pos_d   = 4'd0;
                    leds_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ck_i) begin
        if (rs_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= 2'd0;
            pos_q     <= 4'd0;
            dir_q     <= 1'b0;
            leds_q    <= '0;
            wrap_q    <= 1'b0;
`ifdef LED_SEQ_LOOP_LIMIT_EN
            loops_q   <= 4'd0;
            wrapCnt_q <= 4'd0;
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            leds_q    <= leds_d;
            wrap_q    <= wrap_d;
`ifdef LED_SEQ_LOOP_LIMIT_EN
            loops_q   <= loops_d;
            wrapCnt_q <= wrapCnt_d;
            done_q    <= done_d;
`endif
        end
    end

    assign leds_o = leds_q;
    assign pos_o  = pos_q;
    assign wrap_o = wrap_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl (BASE_DIV=4): vector table, directed corner sequences
// and random control pulses against a step-count reference model.
module tb_led_seq_ctrl;

    localparam int NL  = 10;
    localparam int DIV = 4;

    typedef struct {
        logic       rs;
        logic       start;
        logic       stop;
        logic       pause;
        logic [1:0] mode;
        logic [3:0] speed;
        logic [9:0] leds;
        logic [3:0] pos;
        logic       busy;
        logic       wrap;
    } vec_t;

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] speed = 4'd0;
    logic [9:0] leds;
    logic [3:0] pos;
    logic       busy;
    logic       wrap;
`ifdef LED_SEQ_LOOP_LIMIT_EN
    logic [3:0] loops = 4'd0;
    logic       done;
`endif

    int checks = 0;
    int errors = 0;

    bit mRunning = 1'b0;
    bit mPaused  = 1'b0;
    bit mWrap    = 1'b0;
    int mMode    = 0;
    int mPeriod  = DIV;
    int mCnt     = 0;
    int mK       = 0;

    vec_t tbl [14];
    int   bseq [19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    logic       rndRs, rndStart, rndStop, rndPause;
    logic [1:0] rndMode;
    logic [3:0] rndSpeed;

    always #5 ck = ~ck;

    led_seq_ctrl #(
        .N_LEDS   (NL),
        .BASE_DIV (DIV),
        .PRESC_W  (28)
    ) dut (
        .ck_i    (ck),
        .rs_i    (rs),
        .start_i (start),
        .stop_i  (stop),
        .pause_i (pause),
        .mode_i  (mode),
        .speed_i (speed),
`ifdef LED_SEQ_LOOP_LIMIT_EN
        .loops_i (loops),
        .done_o  (done),
`endif
        .leds_o  (leds),
        .pos_o   (pos),
        .busy_o  (busy),
        .wrap_o  (wrap)
    );

    // Model tracks steps taken since start; pos and leds are derived from that count.
    task automatic modelStep(input logic r, input logic st, input logic sp, input logic pa,
                             input logic [1:0] md, input logic [3:0] spd);
        mWrap = 1'b0;
        if (r || sp) begin
            mRunning = 1'b0;
            mPaused  = 1'b0;
            mCnt     = 0;
            mK       = 0;
        end else if (st) begin
            mRunning = 1'b1;
            mPaused  = 1'b0;
            mMode    = int'(md);
            mPeriod  = (int'(spd) + 1) * DIV;
            mCnt     = 0;
            mK       = 0;
        end else if (mRunning && pa) begin
            mPaused = !mPaused;
        end else if (mRunning && !mPaused) begin
            if (mCnt == mPeriod - 1) begin
                mCnt  = 0;
                mK    = mK + 1;
                mWrap = (mMode == 2) ? (mK % (2 * (NL - 1)) == 0) : (mK % NL == 0);
            end else begin
                mCnt = mCnt + 1;
            end
        end
    endtask

    function automatic int expPos();
        int r;
        if (!mRunning) return 0;
        if (mMode == 2) begin
            r = mK % (2 * (NL - 1));
            return (r <= NL - 1) ? r : 2 * (NL - 1) - r;
        end
        return mK % NL;
    endfunction

    function automatic logic [31:0] expLeds();
        int p;
        if (!mRunning) return 32'd0;
        p = expPos();
        if (mMode == 1) return (32'd1 << (p + 1)) - 32'd1;
        return 32'd1 << p;
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: actual %0h required %0h", tag, what, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] eL, input logic [31:0] eP,
                               input logic eB, input logic eW);
        cmp(tag, "leds", {22'd0, leds}, eL);
        cmp(tag, "pos",  {28'd0, pos},  eP);
        cmp(tag, "busy", {31'd0, busy}, {31'd0, eB});
        cmp(tag, "wrap", {31'd0, wrap}, {31'd0, eW});
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic sp, input logic pa,
                                 input logic [1:0] md, input logic [3:0] spd);
        rs    = r;
        start = st;
        stop  = sp;
        pause = pa;
        mode  = md;
        speed = spd;
        modelStep(r, st, sp, pa, md, spd);
        @(posedge ck);
        #1;
        rs    = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, mode, speed);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 10'h000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 10'h000, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd9, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd7, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd1, 10'h002, 4'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'd0, 10'h000, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd5, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd5, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd5, 10'h001, 4'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd5, 10'h003, 4'd1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 10'h000, 4'd0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].rs, tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].mode, tbl[i].speed);
            checkOutput($sformatf("table[%0d]", i), {22'd0, tbl[i].leds}, {28'd0, tbl[i].pos},
                        tbl[i].busy, tbl[i].wrap);
        end

        // Dot mode, full cycle with wrap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("dot start", 32'h001, 32'd0, 1'b1, 1'b0);
        idle(4);
        checkOutput("dot step1", 32'h002, 32'd1, 1'b1, 1'b0);
        idle(32);
        checkOutput("dot pos9", 32'h200, 32'd9, 1'b1, 1'b0);
        idle(4);
        checkOutput("dot wrap", 32'h001, 32'd0, 1'b1, 1'b1);
        idle(1);
        checkOutput("dot wrap end", 32'h001, 32'd0, 1'b1, 1'b0);

        // Fill mode at speed 1 (8 clocks per step).
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd1);
        checkOutput("fill start", 32'h001, 32'd0, 1'b1, 1'b0);
        idle(8);
        checkOutput("fill step1", 32'h003, 32'd1, 1'b1, 1'b0);
        idle(8);
        checkOutput("fill step2", 32'h007, 32'd2, 1'b1, 1'b0);
        idle(56);
        checkOutput("fill full", 32'h3FF, 32'd9, 1'b1, 1'b0);
        idle(8);
        checkOutput("fill wrap", 32'h001, 32'd0, 1'b1, 1'b1);

        // Bounce mode: endpoints once, wrap only on 1 -> 0.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0);
        checkOutput("bounce start", 32'h001, 32'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            idle(4);
            checkOutput($sformatf("bounce step%0d", k), 32'd1 << bseq[k-1], bseq[k-1], 1'b1, (k == 18));
        end

        // Pause mid-count at pos 3, then pause on a terminal-count cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        idle(13);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
        checkOutput("pause enter", 32'h008, 32'd3, 1'b1, 1'b0);
        idle(20);
        checkOutput("pause hold", 32'h008, 32'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
        idle(2);
        checkOutput("resume count", 32'h008, 32'd3, 1'b1, 1'b0);
        idle(1);
        checkOutput("resume step", 32'h010, 32'd4, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
        checkOutput("pause at tc", 32'h010, 32'd4, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0);
        checkOutput("resume at tc", 32'h010, 32'd4, 1'b1, 1'b0);
        idle(1);
        checkOutput("tc step", 32'h020, 32'd5, 1'b1, 1'b0);

        // Restart from pos 6, then reset mid-run overriding other inputs.
        idle(4);
        checkOutput("reach pos6", 32'h040, 32'd6, 1'b1, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        checkOutput("restart", 32'h001, 32'd0, 1'b1, 1'b0);
        idle(6);
        checkOutput("restart step", 32'h002, 32'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd3);
        checkOutput("reset midrun", 32'h000, 32'd0, 1'b0, 1'b0);
        idle(3);
        checkOutput("reset idle", 32'h000, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rndRs    = ($urandom_range(0, 999) < 3);
            rndStart = ($urandom_range(0, 99) < 2);
            rndStop  = ($urandom_range(0, 99) < 1);
            rndPause = ($urandom_range(0, 99) < 4);
            rndMode  = 2'($urandom_range(0, 3));
            rndSpeed = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            applyStimulus(rndRs, rndStart, rndStop, rndPause, rndMode, rndSpeed);
            checkOutput($sformatf("rand[%0d]", i), expLeds(), expPos(), mRunning, mWrap);
        end

`ifdef LED_SEQ_LOOP_LIMIT_EN
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        loops = 4'd2;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        cmp("loop start", "done", {31'd0, done}, 32'd0);
        idle(40);
        checkOutput("loop wrap1", 32'h001, 32'd0, 1'b1, 1'b1);
        idle(40);
        checkOutput("loop wrap2", 32'h001, 32'd0, 1'b1, 1'b1);
        cmp("loop wrap2", "done", {31'd0, done}, 32'd0);
        idle(1);
        checkOutput("loop end", 32'h000, 32'd0, 1'b0, 1'b0);
        cmp("loop end", "done", {31'd0, done}, 32'd1);
        idle(1);
        cmp("loop after", "done", {31'd0, done}, 32'd0);
        idle(45);
        checkOutput("loop idle", 32'h000, 32'd0, 1'b0, 1'b0);
        cmp("loop idle", "done", {31'd0, done}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
